johnson_seq_gen: RTL and testbench
==================================

JOHNSON_SEQ_GEN -- requirements
Module: johnson_seq_gen

Interface
REQ-001 Parameter: WIDTH, default 4, counter register width (>=2); cycle length 2*WIDTH in Johnson mode, WIDTH in ring mode.
REQ-002 Parameter: DIV_W, default 8, prescaler divisor width (>=1).
REQ-003 Parameter: MODE, default 0, sequence type: 0 = Johnson (twisted ring), 1 = ring (one-hot rotate).
REQ-004 Port: clk, input, 1, single clock; all state on rising edge.
REQ-005 Port: rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port: en, input, 1, advance enable; prescaler runs only when high.
REQ-007 Port: dir, input, 1, direction: 0 = forward (shift toward MSB), 1 = reverse.
REQ-008 Port: div, input, DIV_W, prescale value; one advance per div+1 enabled cycles.
REQ-009 Port: load, input, 1, synchronous load strobe.
REQ-010 Port: load_val, input, WIDTH, value written to q on load.
REQ-011 Port: q, output, WIDTH, registered counter state.
REQ-012 Port: step, output, 1, registered pulse, high for the one cycle following each advance edge.
REQ-013 Port: wrap, output, 1, registered pulse, high with step when the advance returned q to HOME.
REQ-014 Port: err, output, 1, sticky flag: an illegal state was recovered.

Function
REQ-015 HOME = all-zeros when MODE=0; 1 (bit 0 set only) when MODE=1.
REQ-016 Prescaler pre (DIV_W bits): en=1 and pre==div -> advance this edge, pre<=0; en=1 otherwise -> pre<=pre+1; en=0 -> pre holds, no advance.
REQ-017 pre>div (div lowered at runtime) -> pre<=0 with advance, no further counting past div.
REQ-018 div=0 with en=1 -> advance every cycle.
REQ-019 Forward, MODE=0: q<={q[WIDTH-2:0], ~q[WIDTH-1]}; reverse: q<={~q[0], q[WIDTH-1:1]}.
REQ-020 Forward, MODE=1: q<={q[WIDTH-2:0], q[WIDTH-1]}; reverse: q<={q[0], q[WIDTH-1:1]}.
REQ-021 Legal states: MODE=0 -> all-zeros, ones contiguous from LSB, or ones contiguous from MSB (2*WIDTH states); MODE=1 -> exactly one bit set.
REQ-022 On an advance from an illegal q: q<=HOME, err<=1, step=1, wrap=0 (recovery replaces the shift).
REQ-023 wrap=1 only when a normal (legal) shift produces HOME, in either direction.
REQ-024 load=1: q<=load_val, pre<=0, err<=0, no advance, step=0, wrap=0; load has priority over a coincident advance.
REQ-025 Illegal load_val is accepted unchanged; recovery happens at the next advance per REQ-022.
REQ-026 dir changes take effect at the next advance; no extra or lost steps.
REQ-027 step/wrap never high for two consecutive cycles unless div=0 and en=1.

Reset
REQ-028 rst_n low asynchronously forces q=HOME, pre=0, step=0, wrap=0, err=0, regardless of clock.
REQ-029 First advance after rst_n release occurs div+1 enabled cycles later; reset mid-count discards prescaler progress.

Verification
REQ-030 MODE=0, WIDTH=4, div=0, en=1, dir=0 after reset -> q: 0001,0011,0111,1111,1110,1100,1000,0000; wrap only with 0000; step every cycle.
REQ-031 MODE=0, div=2, en=1 -> step every 3rd cycle; en dropped 1 cycle mid-count -> next step delayed exactly 1 cycle.
REQ-032 MODE=0, dir=1 from 0000 -> 1000,1100,1110,1111,0111,0011,0001,0000, wrap on 0000; flip dir at 1110 -> next q=1100.
REQ-033 load_val=0101 then advance -> q=0000, err=1, wrap=0; subsequent load of 0011 -> err=0, q=0011.
REQ-034 load=1 on an advance edge with load_val=0111 -> q=0111, step=0, next step div+1 cycles later.
REQ-035 MODE=1, div=0 -> q: 0010,0100,1000,0001 with wrap on 0001; rst_n pulsed low mid-cycle -> q=0001, err=0 immediately without clock edge.

Source files
------------

// File: rtl/johnson_seq_gen.sv
// Prescaled Johnson / ring sequence generator with direction control, load,
// illegal-state recovery and registered step/wrap strobes.
module johnson_seq_gen #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] HOME = (MODE == 1) ? WIDTH'(1) : '0;

  // Johnson: ones packed against the LSB or against the MSB (zero included).
  // Ring: exactly one bit set.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] inv;
    inv = ~v;
    if (MODE == 1)
      return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    else
      return ((v & (v + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
  endfunction

  function automatic logic [WIDTH-1:0] shift_q(input logic [WIDTH-1:0] v,
                                               input logic             rev);
    if (MODE == 1)
      return rev ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    else
      return rev ? {~v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], ~v[WIDTH-1]};
  endfunction

  logic [DIV_W-1:0] pre;
  logic             pre_hit;
  logic             adv;
  logic             legal;
  logic [WIDTH-1:0] q_shift;

  // pre can sit above div after div is lowered; treat that as an immediate hit
  assign pre_hit = (pre >= div);
  assign adv     = en & pre_hit & ~load;
  assign legal   = is_legal(q);
  assign q_shift = shift_q(q, dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= HOME;
      pre  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      pre  <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      step <= adv;
      wrap <= 1'b0;
      if (en)
        pre <= pre_hit ? '0 : pre + DIV_W'(1);
      if (adv) begin
        if (legal) begin
          q    <= q_shift;
          wrap <= (q_shift == HOME);
        end else begin
          // recovery replaces the shift and is never reported as a wrap
          q   <= HOME;
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Randomized bench for johnson_seq_gen: a Johnson (MODE=0) and a ring (MODE=1)
// instance share stimulus and are compared against a sequence-index model.
module tb_johnson_seq_gen;
  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, dir, load;
  logic [DW-1:0] div;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q0, q1;
  logic          step0, step1, wrap0, wrap1, err0, err1;

  int n_vec = 0;
  int n_err = 0;

  // model state, index 0 = Johnson instance, 1 = ring instance
  int m_q[2];
  int m_step[2];
  int m_wrap[2];
  int m_err[2];
  int m_pre;

  always #5 clk = ~clk;

  johnson_seq_gen #(.WIDTH(W), .DIV_W(DW), .MODE(0)) u_john (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .div(div), .load(load),
    .load_val(load_val), .q(q0), .step(step0), .wrap(wrap0), .err(err0));

  johnson_seq_gen #(.WIDTH(W), .DIV_W(DW), .MODE(1)) u_ring (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .div(div), .load(load),
    .load_val(load_val), .q(q1), .step(step1), .wrap(wrap1), .err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // k-th state of the sequence starting at HOME and walking forward
  function automatic int state_of(input int mode, input int k);
    if (mode == 1) return 1 << k;
    if (k <= W) return (1 << k) - 1;
    return ((1 << W) - 1) & ~((1 << (k - W)) - 1);
  endfunction

  function automatic int seq_len(input int mode);
    return (mode == 1) ? W : 2 * W;
  endfunction

  function automatic int index_of(input int mode, input int v);
    for (int k = 0; k < seq_len(mode); k++)
      if (state_of(mode, k) == v) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_q[m] = state_of(m, 0);
      m_step[m] = 0; m_wrap[m] = 0; m_err[m] = 0;
    end
    m_pre = 0;
  endtask

  task automatic model_edge();
    int hit, idx, nxt;
    if (load) begin
      for (int m = 0; m < 2; m++) begin
        m_q[m] = int'(load_val);
        m_step[m] = 0; m_wrap[m] = 0; m_err[m] = 0;
      end
      m_pre = 0;
      return;
    end
    hit = (en && m_pre >= int'(div)) ? 1 : 0;
    if (en) m_pre = hit ? 0 : m_pre + 1;
    for (int m = 0; m < 2; m++) begin
      m_step[m] = hit;
      m_wrap[m] = 0;
      if (hit) begin
        idx = index_of(m, m_q[m]);
        if (idx < 0) begin
          m_q[m] = state_of(m, 0);
          m_err[m] = 1;
        end else begin
          nxt = dir ? (idx + seq_len(m) - 1) % seq_len(m) : (idx + 1) % seq_len(m);
          m_q[m] = state_of(m, nxt);
          m_wrap[m] = (nxt == 0) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("q_john",    32'(q0),    32'(m_q[0]));
    chk("step_john", 32'(step0), 32'(m_step[0]));
    chk("wrap_john", 32'(wrap0), 32'(m_wrap[0]));
    chk("err_john",  32'(err0),  32'(m_err[0]));
    chk("q_ring",    32'(q1),    32'(m_q[1]));
    chk("step_ring", 32'(step1), 32'(m_step[1]));
    chk("wrap_ring", 32'(wrap1), 32'(m_wrap[1]));
    chk("err_ring",  32'(err1),  32'(m_err[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_q_john", 32'(q0), 32'h0);
    chk("async_rst_q_ring", 32'(q1), 32'h1);
    chk("async_rst_err",    32'({err0, err1}), 32'h0);
    chk("async_rst_step",   32'({step0, step1, wrap0, wrap1}), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int john_exp[8];
    int ring_exp[4];
    int rev_exp[8];
    john_exp = '{1, 3, 7, 15, 14, 12, 8, 0};
    ring_exp = '{2, 4, 8, 1};
    rev_exp  = '{8, 12, 14, 15, 7, 3, 1, 0};

    rst_n = 1'b0; en = 1'b0; dir = 1'b0; div = '0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // forward walk at full rate, against literal sequences
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("fwd_john_lit", 32'(q0), 32'(john_exp[i]));
      chk("fwd_wrap_lit", 32'(wrap0), (i == 7) ? 32'h1 : 32'h0);
      if (i < 4) chk("fwd_ring_lit", 32'(q1), 32'(ring_exp[i]));
    end

    // reverse walk from HOME
    dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rev_john_lit", 32'(q0), 32'(rev_exp[i]));
    end

    // prescale by 3 with a one-cycle enable gap
    div = 8'd2; dir = 1'b0;
    repeat (7) cycle();
    en = 1'b0; cycle(); en = 1'b1;
    repeat (6) cycle();

    // illegal load, recovery, then legal reload
    load = 1'b1; load_val = 4'b0101; cycle(); load = 1'b0;
    div = 8'd0;
    cycle();
    chk("recover_q", 32'(q0), 32'h0);
    chk("recover_err", 32'(err0), 32'h1);
    load = 1'b1; load_val = 4'b0011; cycle(); load = 1'b0;
    chk("reload_err", 32'(err0), 32'h0);

    // load on an advance edge, then async reset mid-cycle
    div = 8'd1; repeat (3) cycle();
    load = 1'b1; load_val = 4'b0111; cycle(); load = 1'b0;
    chk("load_adv_q", 32'(q0), 32'h7);
    repeat (3) cycle();
    pulse_reset();
    repeat (2) cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) div = DW'($urandom_range(0, 4));
      load = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
